// File: rtl/rot_pkg.sv
// Shared types and constants for the quadrature rotary-encoder emulator.
package rot_pkg;

    // {ROT_A, ROT_B} for each phase index
    localparam logic [1:0] AB_PH0 = 2'b00;
    localparam logic [1:0] AB_PH1 = 2'b01;
    localparam logic [1:0] AB_PH2 = 2'b11;
    localparam logic [1:0] AB_PH3 = 2'b10;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef enum logic {IDLE, RUN} rot_state_e;

    function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
        logic [1:0] ab;
        unique case (phase)
            2'd0: ab = AB_PH0;
            2'd1: ab = AB_PH1;
            2'd2: ab = AB_PH2;
            2'd3: ab = AB_PH3;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/rot_phase_seq.sv
// Two-bit up/down phase register with Gray-coded, registered A/B outputs.
module rot_phase_seq
    import rot_pkg::*;
(
    input  logic CLK10K,
    input  logic RST,
    input  logic en,
    input  logic dir,
    output logic ROT_A,
    output logic ROT_B
);

    logic [1:0] phase_q;
    logic [1:0] phase_d;
    logic [1:0] ab_q;

    // Step the phase one position in the commanded direction when enabled.
    always_comb begin
        phase_d = phase_q;
        if (en) begin
            phase_d = (dir == DIR_CW) ? phase_q + 2'd1 : phase_q - 2'd1;
        end
    end

    // Phase and its A/B encoding are registered together so the outputs are glitch-free.
    always_ff @(posedge CLK10K) begin
        if (RST) begin
            phase_q <= 2'd0;
            ab_q    <= AB_PH0;
        end else begin
            phase_q <= phase_d;
            ab_q    <= phase_to_ab(phase_d);
        end
    end

    assign ROT_A = ab_q[1];
    assign ROT_B = ab_q[0];

endmodule

// File: rtl/rot_quad_gen.sv
// Quadrature rotary-encoder emulator: accepts step commands and emits A/B edges at a set rate.
module rot_quad_gen
    import rot_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned PER_W = 8,
    parameter int unsigned POS_W = 16
) (
    input  logic             CLK10K,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_DIR,
    input  logic [CNT_W-1:0] CMD_STEPS,
    input  logic [PER_W-1:0] CMD_PERIOD,
    input  logic             ABORT,
    output logic             ROT_A,
    output logic             ROT_B,
    output logic             BUSY,
    output logic             DONE,
    output logic [POS_W-1:0] POS
);

    rot_state_e       state_q;
    rot_state_e       state_d;
    logic [PER_W-1:0] timer_q;
    logic [PER_W-1:0] period_q;
    logic [CNT_W-1:0] remaining_q;
    logic             dir_q;
    logic [POS_W-1:0] pos_q;
    logic             done_q;

    logic             accept;
    logic             start_run;
    logic [PER_W-1:0] eff_period;
    logic             edge_fire;
    logic             last_edge;

    assign accept     = CMD_VALID && CMD_READY;
    assign start_run  = accept && (CMD_STEPS != '0);
    assign eff_period = (CMD_PERIOD == '0) ? PER_W'(1) : CMD_PERIOD;
    // ABORT wins over a due edge in the same cycle.
    assign edge_fire  = (state_q == RUN) && !ABORT && (timer_q == '0);
    assign last_edge  = edge_fire && (remaining_q == CNT_W'(1));

    // State register.
    always_ff @(posedge CLK10K) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_run) state_d = RUN;
            RUN:  if (ABORT || last_edge) state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        CMD_READY = 1'b0;
        BUSY      = 1'b0;
        unique case (state_q)
            IDLE: CMD_READY = 1'b1;
            RUN:  BUSY      = 1'b1;
        endcase
    end

    // Command latch, edge timer, remaining count, position and DONE pulse.
    always_ff @(posedge CLK10K) begin
        if (RST) begin
            timer_q     <= '0;
            period_q    <= '0;
            remaining_q <= '0;
            dir_q       <= DIR_CCW;
            pos_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            // Zero-step commands complete immediately without entering RUN.
            done_q <= (accept && (CMD_STEPS == '0)) || last_edge;
            if (start_run) begin
                dir_q       <= CMD_DIR;
                remaining_q <= CMD_STEPS;
                period_q    <= eff_period;
                timer_q     <= eff_period - PER_W'(1);
            end else if ((state_q == RUN) && !ABORT) begin
                if (timer_q != '0) begin
                    timer_q <= timer_q - PER_W'(1);
                end else begin
                    timer_q     <= period_q - PER_W'(1);
                    remaining_q <= remaining_q - CNT_W'(1);
                    pos_q       <= (dir_q == DIR_CW) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                end
            end
        end
    end

    rot_phase_seq u_phase_seq (
        .CLK10K (CLK10K),
        .RST    (RST),
        .en     (edge_fire),
        .dir    (dir_q),
        .ROT_A  (ROT_A),
        .ROT_B  (ROT_B)
    );

    assign DONE = done_q;
    assign POS  = pos_q;

endmodule
